digit_scan_display: RTL and testbench
=====================================

Name: digit_scan_display

Overview:
Downstream consumer of the tactile-stepped digit shift chain. It takes the 4-bit digit presented on the chain's low nibble and the debounced step clock, resynchronises the step into the system clock domain, and captures one digit per step into a DIGITS-deep history buffer. The buffer is scanned onto a multiplexed common-anode 7-segment display. Captured values above 9 are flagged as errors.

Parameters:
DIGITS, 4, number of display positions and history buffer depth (2..8)
SCAN_DIV, 50000, sd_clk cycles each digit position stays lit
CNT_W, 16, width of the scan divider counter; must hold SCAN_DIV-1

Ports:
sd_clk  input  1  system clock
sd_preset  input  1  asynchronous active-low reset
sd_step  input  1  debounced step level from the upstream latch; asynchronous to sd_clk
sd_digit  input  4  current digit from the upstream chain output (low nibble)
sd_clear  input  1  synchronous clear, active-high, sampled on sd_clk
sd_seg  output  7  segments {g,f,e,d,c,b,a}, active-low
sd_an  output  DIGITS  anode enables, active-low, one-hot-cold
sd_count  output  4  number of digits captured since reset/clear, saturates at 15
sd_err  output  1  sticky flag: a captured digit was greater than 9

Behaviour:
- Reset (sd_preset=0, async): buffer entries=0; count=0; err=0; scan index=0; divider=0; sync flops=0; sd_an all ones; sd_seg=7'h7F.
- Step sync: 2-flop synchroniser on sd_step, plus a third flop for edge detect. cap_pulse is one cycle wide, asserted when sync2=1 and sync3=0, i.e. 2-3 sd_clk cycles after the sd_step rising edge. Falling edges are ignored.
- Capture: on cap_pulse, sd_digit is sampled directly without a synchroniser. The upstream shift register changed on the same step edge, so its data is settled long before cap_pulse. The shift is buf[0]<=sd_digit and buf[i]<=buf[i-1]; buf[DIGITS-1] is discarded.
- Count: increments on each capture and holds at 15.
- Error: sd_err is set if the sampled digit is greater than 9. It stays set until reset or clear.
- sd_clear: on the next edge it zeroes buffer, count and err. If clear and cap_pulse occur in the same cycle, clear wins and the capture is lost. Scan index and divider are unaffected.
- Scan divider: counts 0..SCAN_DIV-1 and wraps. On wrap, the index advances (idx+1) mod DIGITS.
- Display position idx shows buf[idx]; position 0 is the newest digit.
- Blanking: a position with idx >= count shows 7'h7F, so unfilled positions stay dark.
- Decode: 0-9 use standard active-low patterns (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10). Values 10-15 show dash 7'h3F.
- Output timing: sd_seg and sd_an are registered and reflect the idx/buffer state of the previous cycle. sd_an equals ~(1<<idx) from the first clock after reset release. sd_seg and sd_an always switch on the same edge (no ghosting skew).
- Reset mid-operation: all state returns to reset values immediately. A step that is in flight through the synchroniser is dropped.
- Slow step input: sd_step held high for any duration yields exactly one capture. Step pulses shorter than 2 sd_clk periods are not guaranteed to be seen.

Decomposition:
- Shared include file holds the seven-segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the count saturation value.
- One sub-module, seg7_decode: combinational 4-bit value plus blank input to 7-bit pattern. It is reused by other display labs.
- The synchroniser, edge detect, buffer, divider and output registers stay in the top module.

Test Plan:
(SCAN_DIV=4, DIGITS=4 for all scenarios.)
1. Reset release with no steps -> sd_an cycles 1110, 1101, 1011, 0111, changing every 4 clocks; sd_seg stays 7'h7F; sd_count=0; sd_err=0.
2. Steps with sd_digit 3, 7, 0, 0 in turn -> buf={0,0,7,3} (newest first); sd_count=4. Position 0 shows 7'h40 and position 3 shows 7'h30. Each capture occurs 2-3 clocks after its step edge.
3. After 2 steps with digits 5, 9 -> positions 0 and 1 show 7'h10 and 7'h12; positions 2 and 3 show blank 7'h7F.
4. Step with sd_digit=4'hC -> that position shows 7'h3F and sd_err=1. Eighteen further valid steps -> sd_err stays 1 and sd_count saturates at 15.
5. sd_clear asserted in the same cycle as cap_pulse -> buffer all 0, count=0, err=0, no capture retained; scan continues without a phase jump.
6. sd_step held high for 100 clocks, then sd_preset pulsed low mid-scan -> exactly one capture from the held step. On reset: sd_an=all ones and sd_seg=7'h7F asynchronously; the scan restarts at idx 0.

Source files
------------

// File: rtl/digit_scan_display_pkg.sv
// Shared constants for the digit scan display: active-low seven-segment
// patterns, data widths and the capture count saturation value.
package digit_scan_display_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned COUNT_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [COUNT_W-1:0] COUNT_MAX = 4'd15;

endpackage

// File: rtl/digit_scan_display_seg7_decode.sv
// Combinational 4-bit value to active-low {g,f,e,d,c,b,a} pattern; values
// above 9 show a dash, blank forces all segments off.
module seg7_decode
  import digit_scan_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    if (blank) begin
      seg_c = SEG_BLANK;
    end else begin
      case (value)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/digit_scan_display.sv
// Captures one digit per resynchronised step into a history buffer and scans
// the buffer onto a multiplexed common-anode seven-segment display.
module digit_scan_display
  import digit_scan_display_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 sd_clk,
  input  logic                 sd_preset,
  input  logic                 sd_step,
  input  logic [DIGIT_W-1:0]   sd_digit,
  input  logic                 sd_clear,
  output logic [SEG_W-1:0]     sd_seg,
  output logic [DIGITS-1:0]    sd_an,
  output logic [COUNT_W-1:0]   sd_count,
  output logic                 sd_err
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                 sync1, sync2, sync3;
  logic                 cap_pulse;
  logic [DIGIT_W-1:0]   hist [DIGITS];
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     div;
  logic                 blank;
  logic [SEG_W-1:0]     seg_next;

  // Two-flop synchroniser plus an edge-detect stage; only rising edges capture.
  always_ff @(posedge sd_clk or negedge sd_preset) begin
    if (!sd_preset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sd_step;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign cap_pulse = sync2 & ~sync3;

  // sd_digit settled on the same step edge long before cap_pulse, so it is
  // sampled directly. Clear beats a coincident capture.
  always_ff @(posedge sd_clk or negedge sd_preset) begin
    if (!sd_preset) begin
      for (int i = 0; i < int'(DIGITS); i++) hist[i] <= '0;
      sd_count <= '0;
      sd_err   <= 1'b0;
    end else if (sd_clear) begin
      for (int i = 0; i < int'(DIGITS); i++) hist[i] <= '0;
      sd_count <= '0;
      sd_err   <= 1'b0;
    end else if (cap_pulse) begin
      hist[0] <= sd_digit;
      for (int i = int'(DIGITS) - 1; i > 0; i--) hist[i] <= hist[i-1];
      if (sd_count != COUNT_MAX) sd_count <= sd_count + COUNT_W'(1);
      if (sd_digit > DIGIT_W'(9)) sd_err <= 1'b1;
    end
  end

  // Scan divider and display position index.
  always_ff @(posedge sd_clk or negedge sd_preset) begin
    if (!sd_preset) begin
      div <= '0;
      idx <= '0;
    end else if (div == CNT_W'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + CNT_W'(1);
    end
  end

  assign blank = (COUNT_W'(idx) >= sd_count);

  seg7_decode u_decode (
    .value (hist[idx]),
    .blank (blank),
    .seg_c (seg_next)
  );

  // Segments and anodes share one register stage so they switch together.
  always_ff @(posedge sd_clk or negedge sd_preset) begin
    if (!sd_preset) begin
      sd_seg <= SEG_BLANK;
      sd_an  <= '1;
    end else begin
      sd_seg <= seg_next;
      sd_an  <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_digit_scan_display.sv
// Scoreboard bench for digit_scan_display with DIGITS=4, SCAN_DIV=4.
module tb_digit_scan_display;

  typedef struct {
    logic [3:0] count;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       sd_step;
  logic [3:0] sd_digit;
  logic       sd_clear;
  logic [6:0] sd_seg;
  logic [3:0] sd_an;
  logic [3:0] sd_count;
  logic       sd_err;

  int checks = 0;
  int passed = 0;
  int cyc;

  exp_t       exp_q[$];
  logic [3:0] model_hist [4];
  int         model_count;
  logic       model_err;

  digit_scan_display #(.DIGITS(4), .SCAN_DIV(4), .CNT_W(16)) dut (
    .sd_clk    (clk),
    .sd_preset (rst_n),
    .sd_step   (sd_step),
    .sd_digit  (sd_digit),
    .sd_clear  (sd_clear),
    .sd_seg    (sd_seg),
    .sd_an     (sd_an),
    .sd_count  (sd_count),
    .sd_err    (sd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; drives the expected scan position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (((c - 1) / 4) % 4));
  endfunction

  function automatic logic [6:0] exp_pos(input int p);
    return (p < model_count) ? dec(model_hist[p]) : 7'h7F;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_hist[i] = 4'd0;
    model_count = 0;
    model_err   = 1'b0;
  endtask

  task automatic model_capture(input logic [3:0] d);
    exp_t e;
    for (int i = 3; i > 0; i--) model_hist[i] = model_hist[i-1];
    model_hist[0] = d;
    if (model_count < 15) model_count++;
    if (d > 4'd9) model_err = 1'b1;
    e.count = 4'(model_count);
    e.err   = model_err;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) until position pos is lit and returns its segments.
  task automatic get_seg(input int pos, output logic [6:0] seg, output bit ok);
    logic [3:0] one;
    logic [3:0] want;
    one  = 4'b0001;
    want = ~(one << pos);
    ok   = 1'b0;
    seg  = 7'hxx;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (sd_an === want) begin
        seg = sd_seg;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_step(input logic [3:0] d);
    exp_t e;
    sd_digit = d;
    model_capture(d);
    sd_step = 1'b1;
    repeat (4) @(negedge clk);
    sd_step = 1'b0;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (sd_count !== e.count || sd_err !== e.err)
      $display("FAIL step_%h: count=%0d err=%b expected count=%0d err=%b",
               d, sd_count, sd_err, e.count, e.err);
    else passed++;
  endtask

  task automatic do_clear();
    @(negedge clk);
    sd_clear = 1'b1;
    @(negedge clk);
    sd_clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    checks++;
    if (sd_an !== 4'hF || sd_seg !== 7'h7F || sd_count !== 4'd0 || sd_err !== 1'b0)
      $display("FAIL reset_state: an=%b seg=%h count=%0d err=%b expected an=1111 seg=7f count=0 err=0",
               sd_an, sd_seg, sd_count, sd_err);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 17; n++) begin
      @(negedge clk);
      checks++;
      if (sd_an !== exp_an(cyc) || sd_seg !== 7'h7F || sd_count !== 4'd0 || sd_err !== 1'b0)
        $display("FAIL idle_scan cyc%0d: an=%b seg=%h count=%0d expected an=%b seg=7f count=0",
                 cyc, sd_an, sd_seg, sd_count, exp_an(cyc));
      else passed++;
    end
  endtask

  task automatic test_capture();
    logic [6:0] s;
    bit         ok;
    exp_t       e;
    int         lat;
    sd_digit = 4'd3;
    model_capture(4'd3);
    @(negedge clk);
    sd_step = 1'b1;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (sd_count != 4'd0) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat < 2 || lat > 3)
      $display("FAIL capture_latency: edges=%0d expected 2..3", lat);
    else passed++;
    repeat (3) @(negedge clk);
    sd_step = 1'b0;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (sd_count !== e.count || sd_err !== e.err)
      $display("FAIL step_3: count=%0d err=%b expected count=%0d err=%b",
               sd_count, sd_err, e.count, e.err);
    else passed++;
    do_step(4'd7);
    do_step(4'd0);
    do_step(4'd0);
    for (int p = 0; p < 4; p++) begin
      get_seg(p, s, ok);
      checks++;
      if (!ok || s !== exp_pos(p))
        $display("FAIL capture_pos%0d: seg=%h expected %h", p, s, exp_pos(p));
      else passed++;
    end
  endtask

  task automatic test_blank();
    logic [6:0] s;
    bit         ok;
    do_clear();
    do_step(4'd5);
    do_step(4'd9);
    for (int p = 0; p < 4; p++) begin
      get_seg(p, s, ok);
      checks++;
      if (!ok || s !== exp_pos(p))
        $display("FAIL blank_pos%0d: seg=%h expected %h", p, s, exp_pos(p));
      else passed++;
    end
  endtask

  task automatic test_error_saturate();
    logic [6:0] s;
    bit         ok;
    do_step(4'hC);
    get_seg(0, s, ok);
    checks++;
    if (!ok || s !== 7'h3F)
      $display("FAIL err_dash: seg=%h expected 3f", s);
    else passed++;
    for (int i = 0; i < 18; i++) do_step(4'(i % 10));
    checks++;
    if (sd_count !== 4'd15 || sd_err !== 1'b1)
      $display("FAIL saturate: count=%0d err=%b expected count=15 err=1", sd_count, sd_err);
    else passed++;
  endtask

  task automatic test_clear_collision();
    logic [6:0] s;
    bit         ok;
    exp_t       e;
    sd_digit = 4'd2;
    @(negedge clk);
    sd_step = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sd_clear = 1'b1;
    @(negedge clk);
    sd_clear = 1'b0;
    model_reset();
    e.count = 4'd0;
    e.err   = 1'b0;
    exp_q.push_back(e);
    repeat (3) @(negedge clk);
    sd_step = 1'b0;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (sd_count !== e.count || sd_err !== e.err)
      $display("FAIL clear_wins: count=%0d err=%b expected count=%0d err=%b",
               sd_count, sd_err, e.count, e.err);
    else passed++;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (sd_an !== exp_an(cyc))
        $display("FAIL clear_scan_phase cyc%0d: an=%b expected %b", cyc, sd_an, exp_an(cyc));
      else passed++;
    end
    for (int p = 0; p < 4; p++) begin
      get_seg(p, s, ok);
      checks++;
      if (!ok || s !== 7'h7F)
        $display("FAIL clear_pos%0d: seg=%h expected 7f", p, s);
      else passed++;
    end
  endtask

  task automatic test_held_step_reset();
    exp_t e;
    sd_digit = 4'd6;
    model_capture(4'd6);
    @(negedge clk);
    sd_step = 1'b1;
    repeat (100) @(negedge clk);
    sd_step = 1'b0;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (sd_count !== e.count || sd_err !== e.err)
      $display("FAIL held_step: count=%0d err=%b expected count=%0d err=%b",
               sd_count, sd_err, e.count, e.err);
    else passed++;
    repeat (5) @(negedge clk);
    sd_step = 1'b1;
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    sd_step = 1'b0;
    #1;
    checks++;
    if (sd_an !== 4'hF || sd_seg !== 7'h7F || sd_count !== 4'd0 || sd_err !== 1'b0)
      $display("FAIL async_reset: an=%b seg=%h count=%0d err=%b expected an=1111 seg=7f count=0 err=0",
               sd_an, sd_seg, sd_count, sd_err);
    else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sd_an !== 4'b1110 || sd_seg !== 7'h7F)
      $display("FAIL restart_idx0: an=%b seg=%h expected an=1110 seg=7f", sd_an, sd_seg);
    else passed++;
    repeat (6) @(negedge clk);
    checks++;
    if (sd_count !== 4'd0)
      $display("FAIL inflight_dropped: count=%0d expected 0", sd_count);
    else passed++;
  endtask

  initial begin
    rst_n    = 1'b0;
    sd_step  = 1'b0;
    sd_digit = 4'd0;
    sd_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_capture();
    test_blank();
    test_error_saturate();
    test_clear_collision();
    test_held_step_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
